// File: rtl/vlc_rx_pkg.sv
// rtl/vlc_rx_pkg.sv - shared types and constants for the VLC OOK receive path
package vlc_rx_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] DEF_PREAMBLE = 8'hAA;
  localparam logic [7:0] DEF_SFD      = 8'hD5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/ook_bit_slicer.sv
// rtl/ook_bit_slicer.sv - threshold slicer and majority integrator over one bit window
module ook_bit_slicer
  import vlc_rx_pkg::*;
#(
  parameter int          SPB    = 16,
  parameter logic [11:0] THRESH = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  input  logic        align_en,
  output logic        bit_valid,
  output logic        bit_value
);

  localparam int CW = clog2(SPB);
  localparam int AW = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(SPB - 1);
  localparam logic [AW-1:0] HALF = AW'(SPB / 2);

  logic [CW-1:0] win_cnt;
  logic [AW-1:0] ones;
  logic          prev_chip;

  logic          chip;
  logic          edge_hit;
  logic [CW-1:0] pos;
  logic [AW-1:0] ones_sum;

  // A chip transition while hunting makes the current sample position 0 of a new window.
  always_comb begin
    chip      = (sample_in >= THRESH);
    edge_hit  = align_en && (chip != prev_chip);
    pos       = edge_hit ? '0 : win_cnt;
    ones_sum  = (edge_hit ? '0 : ones) + AW'(chip);
    bit_valid = sample_valid && (pos == LAST);
    bit_value = (ones_sum >= HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      ones      <= '0;
      prev_chip <= 1'b0;
    end else if (sample_valid) begin
      prev_chip <= chip;
      if (pos == LAST) begin
        win_cnt <= '0;
        ones    <= '0;
      end else begin
        win_cnt <= pos + 1'b1;
        ones    <= ones_sum;
      end
    end
  end

endmodule

// File: rtl/vlc_ook_demod.sv
// rtl/vlc_ook_demod.sv - OOK demodulator: preamble hunt, SFD lock and fixed-length byte framing
module vlc_ook_demod
  import vlc_rx_pkg::*;
#(
  parameter int          SPB         = 16,
  parameter logic [11:0] THRESH      = 12'h800,
  parameter logic [7:0]  PREAMBLE    = DEF_PREAMBLE,
  parameter logic [7:0]  SFD         = DEF_SFD,
  parameter int          FRAME_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_active,
  output logic        frame_done,
  output logic        bit_out
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_t     state;
  logic [7:0] shreg;
  logic [7:0] sh_next;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [3:0] sync_cnt;
  logic       bit_valid;
  logic       bit_value;

  ook_bit_slicer #(
    .SPB    (SPB),
    .THRESH (THRESH)
  ) u_slicer (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .align_en     (state == HUNT),
    .bit_valid    (bit_valid),
    .bit_value    (bit_value)
  );

  assign sh_next = {shreg[6:0], bit_value};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      shreg        <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      sync_cnt     <= '0;
      byte_out     <= '0;
      byte_valid   <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      bit_out      <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      if (bit_valid) begin
        shreg   <= sh_next;
        bit_out <= bit_value;
        case (state)
          HUNT: begin
            if (sh_next == PREAMBLE) begin
              state    <= SYNC;
              sync_cnt <= '0;
            end
          end
          SYNC: begin
            // A repeating preamble restarts the SFD timeout.
            if (sh_next == SFD) begin
              state        <= DATA;
              frame_active <= 1'b1;
              bit_cnt      <= '0;
              byte_cnt     <= '0;
            end else if (sh_next == PREAMBLE) begin
              sync_cnt <= '0;
            end else if (sync_cnt == 4'd15) begin
              state <= HUNT;
            end else begin
              sync_cnt <= sync_cnt + 4'd1;
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_out   <= sh_next;
              byte_valid <= 1'b1;
              byte_cnt   <= byte_cnt + 8'd1;
              if (byte_cnt == LAST_BYTE) begin
                frame_done   <= 1'b1;
                frame_active <= 1'b0;
                state        <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/vlc_ook_demod.md
Name: vlc_ook_demod

Overview:
- Receive-side OOK demodulator. It sits directly downstream of the XADC capture stage and consumes its 12-bit sample word plus a one-cycle sample strobe.
- Slices each sample against a threshold and integrates the slices over a bit window. It hunts for the preamble, locks on the start-of-frame delimiter (SFD), then emits fixed-length frames as bytes with a valid strobe.

Parameters:
- SPB, 16: ADC samples per bit; power of two, 4..64.
- THRESH, 12'h800: slicing level; sample >= THRESH gives chip 1.
- PREAMBLE, 8'hAA: byte that must be seen before the SFD.
- SFD, 8'hD5: start-of-frame delimiter.
- FRAME_BYTES, 4: payload bytes per frame, 1..255.

Ports:
- clk  in  1  system clock (same domain as the ADC capture stage).
- rst_n  in  1  asynchronous, active-low reset.
- sample_in  in  12  ADC sample (data_out of the capture stage).
- sample_valid  in  1  one-cycle strobe, new sample present; the upstream stage synchronises it into clk.
- byte_out  out  8  received payload byte, MSB first on air.
- byte_valid  out  1  one-cycle pulse, byte_out valid.
- frame_active  out  1  high from SFD match until the last payload byte.
- frame_done  out  1  one-cycle pulse together with the last byte_valid.
- bit_out  out  1  last decided bit (debug).

Behaviour:
- Reset (async assert, sync release): all outputs 0; state HUNT; counters, accumulator and shift register cleared.
- Samples are processed only on cycles with sample_valid=1. Cycles without it change nothing.
- Chip = (sample_in >= THRESH), unsigned compare.
- Ones-accumulator: width clog2(SPB)+1, counts chips equal to 1 within the window.
- Window counter: 0..SPB-1, wraps.
- Bit decision: on the sample where the window counter equals SPB-1, bit = (ones incl. current chip) >= SPB/2. Ties decide 1. The accumulator then restarts at 0.
- Edge alignment, HUNT only: if chip differs from the previous chip, the window counter is forced to 0 and the accumulator restarts with the current chip. This aligns windows to transitions. No realignment happens in SYNC or DATA.
- Decided bits shift into an 8-bit register from the LSB; the oldest bit is the MSB.
- State HUNT: when the shift register equals PREAMBLE after a decision, go to SYNC.
- State SYNC:
  - Shift register equals SFD: go to DATA, set frame_active=1, clear the bit and byte counters.
  - Shift register equals PREAMBLE: stay in SYNC (preamble repeating).
  - 16 decisions with neither match: go back to HUNT.
- State DATA:
  - Every 8th decision: byte_out = shift register, byte_valid pulses.
  - After FRAME_BYTES bytes: frame_done pulses with the last byte_valid, frame_active drops, state returns to HUNT.
- Latency: byte_valid rises on the clk edge following the sample_valid cycle that completes the 8th bit's window. It is registered, so there is one cycle of latency.
- byte_out holds its value until the next byte_valid.
- bit_out updates on every decision in all states.
- Reset mid-frame: frame_active drops immediately and no frame_done is issued.
- sample_valid on consecutive cycles is legal: one sample per cycle, with no backpressure.

Decomposition:
- Package vlc_rx_pkg:
  - state enum {HUNT, SYNC, DATA};
  - default PREAMBLE and SFD constants;
  - function clog2.
- Sub-module ook_bit_slicer: threshold, ones-accumulator, window counter and edge realignment. It outputs bit_valid and bit, takes an align_en input, and shares clk and rst_n.
- The top level holds the framing FSM, the shift register and the byte/frame counters.

Test Plan:
- Idle line: constant 12'h100 for 500 samples -> no byte_valid, state stays HUNT, bit_out=0.
- Clean frame:
  - stimulus, SPB=16: 2x 8'hAA, 8'hD5, payload 8'h12 8'h34 8'h56 8'h78; ones=12'hF00, zeros=12'h050.
  - response: four byte_valid pulses carrying 12,34,56,78; frame_done with the 78 pulse; frame_active high exactly from the SFD decision to that pulse.
- Phase offset and noise: same frame with a leading 5-sample offset, plus 3 of 16 samples per bit flipped -> identical bytes, because edge alignment corrects the offset in HUNT.
- Sparse strobe: sample_valid every 3rd clk -> same bytes; byte_valid is exactly one cycle wide.
- SFD timeout: 8'hAA followed by 16 bits of 8'h00 pattern -> return to HUNT, no byte_valid. A subsequent correct frame is then received.
- Reset mid-frame: rst_n low after the 2nd payload byte -> all outputs 0 asynchronously, no frame_done. The next full frame decodes correctly.
